// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
// The statistics helper is used only when BURST_MEM_STATS_EN is defined.
package burst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        RELEASE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_W      = 256;
    localparam int LINE_OFFSET = 5;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Line store organised as 2**ADDR_WIDTH lines of four 64-bit beats.
// A single beat-wide port: the write takes effect at the clock edge, and the
// read data is registered, so it appears the cycle after the address.
// Contents are never reset.
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] line,
    input  logic [1:0]            beat,
    input  logic                  we,
    input  logic [BEAT_W-1:0]     wdata,
    output logic [BEAT_W-1:0]     rdata
);

    localparam int DEPTH = (2 ** ADDR_WIDTH) * (LINE_W / BEAT_W);

    logic [BEAT_W-1:0] mem [DEPTH];

    // Write the addressed beat when enabled; register the addressed beat as read data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{line, beat}] <= wdata;
        end
        rdata <= mem[{line, beat}];
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat x 64-bit line burst protocol.
// Flow: accept a request, wait LATENCY cycles, then transfer four beats.
// Each beat is marked by resp_o. After the last beat the responder waits in
// RELEASE until the initiator drops its request.
// Optional feature (macro BURST_MEM_STATS_EN): saturating read, write and
// abort counters on rd_count_o, wr_count_o and abort_count_o.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o
`ifdef BURST_MEM_STATS_EN
    ,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o,
    output logic [31:0]       abort_count_o
`endif
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT  = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
    localparam logic [1:0]       LAST_BEAT = 2'(BEATS - 1);

    state_t                  state, state_next;
    op_t                     op;
    logic [ADDR_WIDTH-1:0]   line;
    logic [ADDR_WIDTH-1:0]   index_in;
    logic [1:0]              beat, beat_next;
    logic [CNT_W-1:0]        lat_cnt, lat_next;
    logic                    accept;
    logic                    active_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_line;
    logic [1:0]              mem_beat;
    logic [BEAT_W-1:0]       rdata;
    logic                    unused_addr;

    assign index_in    = address_i[ADDR_WIDTH+LINE_OFFSET-1:LINE_OFFSET];
    assign unused_addr = ^{address_i[31:ADDR_WIDTH+LINE_OFFSET], address_i[LINE_OFFSET-1:0]};

    // Only the request line matching the latched operation keeps a transaction alive.
    assign active_req = (op == OP_READ) ? read_i : write_i;

    // Next-state logic: sequencing, latency countdown and beat advance.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        lat_next   = lat_cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (read_i || write_i) begin
                    accept    = 1'b1;
                    beat_next = 2'd0;
                    if (LATENCY == 0) begin
                        state_next = BURST;
                    end else begin
                        state_next = WAIT;
                        lat_next   = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!active_req) begin
                    state_next = IDLE;
                end else if (lat_cnt == '0) begin
                    state_next = BURST;
                    beat_next  = 2'd0;
                end else begin
                    lat_next = lat_cnt - 1'b1;
                end
            end
            BURST: begin
                if (!active_req) begin
                    state_next = IDLE;
                    beat_next  = 2'd0;
                end else if (beat == LAST_BEAT) begin
                    state_next = RELEASE;
                    beat_next  = 2'd0;
                end else begin
                    beat_next = beat + 2'd1;
                end
            end
            RELEASE: begin
                if (!read_i && !write_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and the latched request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            beat    <= 2'd0;
            lat_cnt <= '0;
            op      <= OP_READ;
            line    <= '0;
        end else begin
            state   <= state_next;
            beat    <= beat_next;
            lat_cnt <= lat_next;
            if (accept) begin
                op   <= read_i ? OP_READ : OP_WRITE;
                line <= index_in;
            end
        end
    end

    // Reads prefetch the beat that will be shown next cycle, so the registered
    // array output is aligned with resp_o. Writes address the current beat.
    assign mem_we   = (state == BURST) && (op == OP_WRITE) && write_i;
    assign mem_line = (state == IDLE) ? index_in : line;
    assign mem_beat = mem_we ? beat : beat_next;

    burst_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .line  (mem_line),
        .beat  (mem_beat),
        .we    (mem_we),
        .wdata (burst_i),
        .rdata (rdata)
    );

    assign resp_o  = (state == BURST);
    assign burst_o = (resp_o && (op == OP_READ)) ? rdata : '0;

`ifdef BURST_MEM_STATS_EN
    logic done;
    logic abort;

    assign done  = (state == BURST) && (beat == LAST_BEAT) && active_req;
    assign abort = ((state == WAIT) || (state == BURST)) && !active_req;

    // Saturating transaction counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_count_o    <= '0;
            wr_count_o    <= '0;
            abort_count_o <= '0;
        end else begin
            if (done && (op == OP_READ)) begin
                rd_count_o <= sat_inc(rd_count_o);
            end
            if (done && (op == OP_WRITE)) begin
                wr_count_o <= sat_inc(wr_count_o);
            end
            if (abort) begin
                abort_count_o <= sat_inc(abort_count_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed testbench for burst_mem_responder.
// Two instances are exercised: one with LATENCY=4 and one with LATENCY=0.
// The statistics outputs are checked when BURST_MEM_STATS_EN is defined.
module tb_burst_mem_responder;

    localparam logic [255:0] LINE_A = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    localparam logic [255:0] LINE_B = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
    localparam logic [255:0] LINE_C = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    localparam logic [255:0] LINE_D = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    localparam logic [255:0] LINE_F = {64'hFF, 64'hFF, 64'hFF, 64'hFF};
    localparam logic [255:0] LINE_M = {64'hA3, 64'hA2, 64'hC1, 64'hC0};

    logic        clk;
    logic        reset_n;
    logic [31:0] address_i;
    logic [63:0] burst_i;
    logic        read4, write4, resp4;
    logic        read0, write0, resp0;
    logic [63:0] burst4, burst0;
    logic        resp_mon;
    logic [63:0] burst_mon;
    int          sel;
    int          checks;
    int          failures;

`ifdef BURST_MEM_STATS_EN
    logic [31:0] rd_cnt4, wr_cnt4, ab_cnt4;
    logic [31:0] unused_rd0, unused_wr0, unused_ab0;
`endif

    burst_mem_responder #(.ADDR_WIDTH(5), .LATENCY(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address_i     (address_i),
        .read_i        (read4),
        .write_i       (write4),
        .burst_i       (burst_i),
        .burst_o       (burst4),
        .resp_o        (resp4)
`ifdef BURST_MEM_STATS_EN
        ,
        .rd_count_o    (rd_cnt4),
        .wr_count_o    (wr_cnt4),
        .abort_count_o (ab_cnt4)
`endif
    );

    burst_mem_responder #(.ADDR_WIDTH(5), .LATENCY(0)) dut0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .address_i     (address_i),
        .read_i        (read0),
        .write_i       (write0),
        .burst_i       (burst_i),
        .burst_o       (burst0),
        .resp_o        (resp0)
`ifdef BURST_MEM_STATS_EN
        ,
        .rd_count_o    (unused_rd0),
        .wr_count_o    (unused_wr0),
        .abort_count_o (unused_ab0)
`endif
    );

    assign resp_mon  = (sel == 0) ? resp0 : resp4;
    assign burst_mon = (sel == 0) ? burst0 : burst4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, actual, expected);
        end
    endtask

    // Drive the request lines of the selected instance and route its outputs to the monitor.
    task automatic setReq(input int which, input logic rd, input logic wr);
        sel = which;
        if (which == 0) begin
            read0  = rd;
            write0 = wr;
        end else begin
            read4  = rd;
            write4 = wr;
        end
    endtask

    // Run one full line transaction on the selected instance.
    // The request is held through 'hold' cycles past the last beat before it drops.
    task automatic applyStimulus(input string tag, input int which, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [255:0] wline,
                                 input logic [255:0] rline, input int hold);
        int   lat;
        logic exp_resp;
        lat = (which == 0) ? 0 : 4;
        @(negedge clk);
        address_i = addr;
        burst_i   = '0;
        setReq(which, rd, wr);
        for (int c = 1; c <= lat + 4 + hold; c++) begin
            @(negedge clk);
            exp_resp = (c > lat) && (c <= lat + 4);
            checkOutput($sformatf("%s_resp_c%0d", tag, c), 64'(resp_mon), 64'(exp_resp));
            if (exp_resp) begin
                if (rd) begin
                    checkOutput($sformatf("%s_data_b%0d", tag, c - lat - 1), burst_mon,
                                rline[(c - lat - 1) * 64 +: 64]);
                end else begin
                    checkOutput($sformatf("%s_wrzero_b%0d", tag, c - lat - 1), burst_mon, 64'h0);
                end
                burst_i = wline[(c - lat - 1) * 64 +: 64];
            end else begin
                checkOutput($sformatf("%s_idle_data_c%0d", tag, c), burst_mon, 64'h0);
            end
        end
        setReq(which, 1'b0, 1'b0);
        burst_i = '0;
        @(negedge clk);
        checkOutput($sformatf("%s_after", tag), 64'(resp_mon), 64'h0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        sel       = 4;
        reset_n   = 1'b0;
        address_i = '0;
        burst_i   = '0;
        read4     = 1'b0;
        write4    = 1'b0;
        read0     = 1'b0;
        write0    = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_resp4", 64'(resp4), 64'h0);
        checkOutput("reset_burst4", burst4, 64'h0);
        checkOutput("reset_resp0", 64'(resp0), 64'h0);
        checkOutput("reset_burst0", burst0, 64'h0);
`ifdef BURST_MEM_STATS_EN
        checkOutput("reset_rdcnt", 64'(rd_cnt4), 64'h0);
`endif
        reset_n = 1'b1;

        $display("[TB] write/read with latency 4");
        applyStimulus("wr40", 4, 1'b0, 1'b1, 32'h0000_0040, LINE_A, '0, 1);
        applyStimulus("wr80", 4, 1'b0, 1'b1, 32'h0000_0080, LINE_B, '0, 1);
        applyStimulus("rd40", 4, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_A, 1);
        applyStimulus("rd5c", 4, 1'b1, 1'b0, 32'h0000_005C, '0, LINE_A, 1);
        applyStimulus("rd440", 4, 1'b1, 1'b0, 32'h0000_0440, '0, LINE_A, 1);

        $display("[TB] read abort after two beats");
        @(negedge clk);
        address_i = 32'h0000_0080;
        setReq(4, 1'b1, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                checkOutput($sformatf("abort_resp_c%0d", c), 64'(resp4), 64'h1);
                checkOutput($sformatf("abort_data_c%0d", c), burst4, LINE_B[(c - 5) * 64 +: 64]);
            end
        end
        setReq(4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort_resp_drop", 64'(resp4), 64'h0);
        checkOutput("abort_burst_drop", burst4, 64'h0);
        applyStimulus("rd80", 4, 1'b1, 1'b0, 32'h0000_0080, '0, LINE_B, 1);

        $display("[TB] read and write both high");
        applyStimulus("both40", 4, 1'b1, 1'b1, 32'h0000_0040, LINE_F, LINE_A, 1);
        applyStimulus("rd40b", 4, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_A, 1);
`ifdef BURST_MEM_STATS_EN
        checkOutput("stats_rd", 64'(rd_cnt4), 64'd6);
        checkOutput("stats_wr", 64'(wr_cnt4), 64'd2);
        checkOutput("stats_abort", 64'(ab_cnt4), 64'd1);
`endif

        $display("[TB] latency 0 instance");
        applyStimulus("l0wr40", 0, 1'b0, 1'b1, 32'h0000_0040, LINE_D, '0, 1);
        applyStimulus("l0rd40", 0, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_D, 3);

        $display("[TB] reset during write beat 2");
        @(negedge clk);
        address_i = 32'h0000_0040;
        setReq(4, 1'b0, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                burst_i = LINE_C[(c - 5) * 64 +: 64];
            end
        end
        checkOutput("rst_beat2_resp", 64'(resp4), 64'h1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_resp_drop", 64'(resp4), 64'h0);
        checkOutput("rst_burst_drop", burst4, 64'h0);
        setReq(4, 1'b0, 1'b0);
        burst_i = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
`ifdef BURST_MEM_STATS_EN
        checkOutput("rst_stats_rd", 64'(rd_cnt4), 64'h0);
        checkOutput("rst_stats_wr", 64'(wr_cnt4), 64'h0);
        checkOutput("rst_stats_abort", 64'(ab_cnt4), 64'h0);
`endif
        applyStimulus("rdmix", 4, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_M, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
